// File: rtl/mem_stage.sv
// Memory stage of the five-stage ARM pipeline: EX/MEM and MEM/WB registers plus a
// req/ack load/store engine that freezes the upstream pipeline while an access is open.
module mem_stage #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] val_Rm_in,
  input  logic [3:0]  Dest_in,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        freeze,
  output logic [31:0] ALU_Res,
  output logic [3:0]  Dest_mem,
  output logic        WB_EN_mem,
  output logic [31:0] WB_Val,
  output logic [3:0]  Dest_wb,
  output logic        WB_EN_wb,
  output logic        mem_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              done_reg, done_next;
  logic [31:0]       load_data_reg, load_data_next;
  logic              err_reg, err_next;

  // EX/MEM register
  logic [31:0] alu_res_reg;
  logic [31:0] val_rm_reg;
  logic [3:0]  dest_mem_reg;
  logic        wb_en_mem_reg;
  logic        mem_r_en_reg;
  logic        mem_w_en_reg;

  // MEM/WB register
  logic [31:0] wb_val_reg;
  logic [3:0]  dest_wb_reg;
  logic        wb_en_wb_reg;

  logic mem_op;
  logic busy;

  assign mem_op = mem_r_en_reg | mem_w_en_reg;
  assign busy   = (state_reg == BUSY);
  // The op stays frozen in EX/MEM until its handshake has finished.
  assign freeze = mem_op & ~done_reg;

  assign mem_req   = busy;
  assign mem_we    = busy & mem_w_en_reg;
  assign mem_addr  = busy ? ((alu_res_reg - ADDR_BASE) >> 2) : 32'd0;
  assign mem_wdata = busy ? val_rm_reg : 32'd0;

  assign ALU_Res   = alu_res_reg;
  assign Dest_mem  = dest_mem_reg;
  assign WB_EN_mem = wb_en_mem_reg;
  assign WB_Val    = wb_val_reg;
  assign Dest_wb   = dest_wb_reg;
  assign WB_EN_wb  = wb_en_wb_reg;
  assign mem_err   = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    done_next      = done_reg;
    load_data_next = load_data_reg;
    err_next       = err_reg;
    if (!freeze) done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op && !done_reg) begin
          state_next = BUSY;
          count_next = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_next     = IDLE;
          load_data_next = mem_rdata;
          done_next      = 1'b1;
        end else if (count_reg == CNT_LAST) begin
          // Give up: complete with zero data and flag the error until reset.
          state_next     = IDLE;
          load_data_next = 32'd0;
          done_next      = 1'b1;
          err_next       = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg     <= '0;
      done_reg      <= 1'b0;
      load_data_reg <= 32'd0;
      err_reg       <= 1'b0;
      alu_res_reg   <= 32'd0;
      val_rm_reg    <= 32'd0;
      dest_mem_reg  <= 4'd0;
      wb_en_mem_reg <= 1'b0;
      mem_r_en_reg  <= 1'b0;
      mem_w_en_reg  <= 1'b0;
      wb_val_reg    <= 32'd0;
      dest_wb_reg   <= 4'd0;
      wb_en_wb_reg  <= 1'b0;
    end else begin
      count_reg     <= count_next;
      done_reg      <= done_next;
      load_data_reg <= load_data_next;
      err_reg       <= err_next;
      if (!freeze) begin
        alu_res_reg   <= ALU_result_in;
        val_rm_reg    <= val_Rm_in;
        dest_mem_reg  <= Dest_in;
        wb_en_mem_reg <= WB_EN_in;
        mem_r_en_reg  <= MEM_R_EN_in;
        mem_w_en_reg  <= MEM_W_EN_in;
      end
      if (freeze) begin
        wb_en_wb_reg <= 1'b0;
      end else begin
        // Stores never write back, whatever WB_EN says.
        wb_en_wb_reg <= wb_en_mem_reg & ~mem_w_en_reg;
        dest_wb_reg  <= dest_mem_reg;
        wb_val_reg   <= mem_r_en_reg ? load_data_reg : alu_res_reg;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load, store, timeout,
// back-to-back loads and reset during an outstanding access.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_result_in;
  logic [31:0] val_Rm_in;
  logic [3:0]  Dest_in;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic [31:0] ALU_Res;
  logic [3:0]  Dest_mem;
  logic        WB_EN_mem;
  logic [31:0] WB_Val;
  logic [3:0]  Dest_wb;
  logic        WB_EN_wb;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.ADDR_BASE(32'd1024), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .ALU_result_in(ALU_result_in), .val_Rm_in(val_Rm_in), .Dest_in(Dest_in),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .freeze(freeze),
    .ALU_Res(ALU_Res), .Dest_mem(Dest_mem), .WB_EN_mem(WB_EN_mem),
    .WB_Val(WB_Val), .Dest_wb(Dest_wb), .WB_EN_wb(WB_EN_wb), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dest,
                       input logic wb, input logic rd, input logic wr);
    ALU_result_in = alu;
    val_Rm_in     = rm;
    Dest_in       = dest;
    WB_EN_in      = wb;
    MEM_R_EN_in   = rd;
    MEM_W_EN_in   = wr;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_wbval", WB_Val, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    step();
    step();
    rst = 1'b1;

    // ALU op passes through without stall
    drive(32'h0000_0005, 32'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk("alu_freeze_e1", {31'd0, freeze}, 32'd0);
    chk("alu_exmem_res", ALU_Res, 32'd5);
    chk("alu_exmem_dest", {28'd0, Dest_mem}, 32'd3);
    chk("alu_wben_e1", {31'd0, WB_EN_wb}, 32'd0);
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("alu_freeze_e2", {31'd0, freeze}, 32'd0);
    chk("alu_wbval", WB_Val, 32'd5);
    chk("alu_destwb", {28'd0, Dest_wb}, 32'd3);
    chk("alu_wben", {31'd0, WB_EN_wb}, 32'd1);
    $display("txn alu result=5 dest=3");

    // Load at 1032, ack on the third request cycle
    drive(32'd1032, 32'd0, 4'd7, 1'b1, 1'b1, 1'b0);
    step();
    chk("ld_freeze_c1", {31'd0, freeze}, 32'd1);
    chk("ld_req_c1", {31'd0, mem_req}, 32'd0);
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld_freeze_c2", {31'd0, freeze}, 32'd1);
    chk("ld_req_c2", {31'd0, mem_req}, 32'd1);
    chk("ld_addr", mem_addr, 32'd2);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    chk("ld_bubble", {31'd0, WB_EN_wb}, 32'd0);
    step();
    chk("ld_freeze_c3", {31'd0, freeze}, 32'd1);
    step();
    chk("ld_freeze_c4", {31'd0, freeze}, 32'd1);
    chk("ld_req_c4", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    chk("ld_freeze_done", {31'd0, freeze}, 32'd0);
    chk("ld_req_done", {31'd0, mem_req}, 32'd0);
    chk("ld_bubble_done", {31'd0, WB_EN_wb}, 32'd0);
    step();
    chk("ld_wbval", WB_Val, 32'hDEAD_BEEF);
    chk("ld_destwb", {28'd0, Dest_wb}, 32'd7);
    chk("ld_wben", {31'd0, WB_EN_wb}, 32'd1);
    $display("txn load addr=2 data=deadbeef");

    // Store at 1028, ack in the first request cycle
    drive(32'd1028, 32'h0000_1234, 4'd2, 1'b1, 1'b0, 1'b1);
    step();
    chk("st_freeze_c1", {31'd0, freeze}, 32'd1);
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("st_freeze_c2", {31'd0, freeze}, 32'd1);
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_addr", mem_addr, 32'd1);
    chk("st_wdata", mem_wdata, 32'h0000_1234);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    chk("st_freeze_done", {31'd0, freeze}, 32'd0);
    chk("st_req_done", {31'd0, mem_req}, 32'd0);
    step();
    chk("st_no_wb", {31'd0, WB_EN_wb}, 32'd0);
    $display("txn store addr=1 data=00001234");

    // Load that never gets an ack
    drive(32'd2000, 32'd0, 4'd5, 1'b1, 1'b1, 1'b0);
    step();
    chk("to_freeze_c1", {31'd0, freeze}, 32'd1);
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("to_req_%0d", i), {31'd0, mem_req}, 32'd1);
    end
    chk("to_err_pending", {31'd0, mem_err}, 32'd0);
    step();
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_freeze_done", {31'd0, freeze}, 32'd0);
    step();
    chk("to_wbval", WB_Val, 32'd0);
    chk("to_destwb", {28'd0, Dest_wb}, 32'd5);
    chk("to_wben", {31'd0, WB_EN_wb}, 32'd1);
    $display("txn load timeout addr=%0d err=%0d", (2000 - 1024) / 4, mem_err);

    // Two consecutive loads
    drive(32'd1040, 32'd0, 4'd8, 1'b1, 1'b1, 1'b0);
    step();
    drive(32'd1044, 32'd0, 4'd9, 1'b1, 1'b1, 1'b0);
    step();
    chk("b2b_a_addr", mem_addr, 32'd4);
    mem_ack = 1'b1;
    mem_rdata = 32'hAAAA_0001;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    chk("b2b_a_req_done", {31'd0, mem_req}, 32'd0);
    step();
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_a_wbval", WB_Val, 32'hAAAA_0001);
    chk("b2b_a_destwb", {28'd0, Dest_wb}, 32'd8);
    chk("b2b_a_wben", {31'd0, WB_EN_wb}, 32'd1);
    chk("b2b_gap_req", {31'd0, mem_req}, 32'd0);
    chk("b2b_b_freeze", {31'd0, freeze}, 32'd1);
    step();
    chk("b2b_b_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_b_addr", mem_addr, 32'd5);
    mem_ack = 1'b1;
    mem_rdata = 32'hBBBB_0002;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    chk("b2b_b_req_done", {31'd0, mem_req}, 32'd0);
    step();
    chk("b2b_b_wbval", WB_Val, 32'hBBBB_0002);
    chk("b2b_b_destwb", {28'd0, Dest_wb}, 32'd9);
    chk("b2b_b_wben", {31'd0, WB_EN_wb}, 32'd1);
    $display("txn load pair data=aaaa0001,bbbb0002");

    // Reset while a load is outstanding
    drive(32'd1100, 32'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("rb_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    drive(32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rb_req", {31'd0, mem_req}, 32'd0);
    chk("rb_freeze", {31'd0, freeze}, 32'd0);
    chk("rb_alures", ALU_Res, 32'd0);
    chk("rb_wbval", WB_Val, 32'd0);
    chk("rb_err", {31'd0, mem_err}, 32'd0);
    #2;
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    step();
    chk("rb_late_wben", {31'd0, WB_EN_wb}, 32'd0);
    chk("rb_late_wbval", WB_Val, 32'd0);
    chk("rb_late_req", {31'd0, mem_req}, 32'd0);
    $display("txn reset during busy, late ack ignored");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage ARM pipeline. Sits directly after the execute stage and consumes its outputs (ALU result, Rm value, Dest, WB_EN, MEM_R_EN, MEM_W_EN).
- Holds the EX/MEM pipeline register and performs loads and stores over a req/ack handshake to external data memory. Freezes the upstream pipeline while an access is outstanding.
- Holds the MEM/WB register. Feeds ALU_Res and WB_Val back to the execute-stage forwarding muxes.

Parameters:
- ADDR_BASE, 1024: byte offset subtracted from the ALU result to form the memory address.
- TIMEOUT, 15: maximum cycles to wait for mem_ack before the access is forced to complete with an error.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ALU_result_in  in  32  execute-stage ALU result (address, or data for non-memory ops).
- val_Rm_in  in  32  store data.
- Dest_in  in  4  destination register.
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  execute-stage control.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  word address, computed as (ALU result − ADDR_BASE) >> 2.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory acknowledge, one cycle per transfer.
- mem_rdata  in  32  load data; valid when mem_ack = 1.
- freeze  out  1  stall for IF/ID/EX registers.
- ALU_Res  out  32  EX/MEM ALU result (forwarding source).
- Dest_mem  out  4  EX/MEM Dest.
- WB_EN_mem  out  1  EX/MEM WB_EN.
- WB_Val  out  32  MEM/WB write-back value.
- Dest_wb  out  4  MEM/WB Dest.
- WB_EN_wb  out  1  MEM/WB WB_EN.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst = 0, asynchronous): all registers and outputs are 0; state is IDLE; mem_req drops immediately. Reset during an access abandons it; a mem_ack arriving after reset is released is ignored.
- EX/MEM register: loads all *_in signals on each rising edge when freeze = 0. It holds its contents when freeze = 1.
- mem_op = MEM_R_EN_mem | MEM_W_EN_mem. A flag 'done' is set on completion and cleared whenever EX/MEM loads.
- FSM has two states, IDLE and BUSY.
  - IDLE → BUSY when mem_op = 1 and done = 0. mem_req rises in the first BUSY cycle, i.e. one cycle after the op enters EX/MEM.
  - In BUSY: mem_req = 1, and mem_we/mem_addr/mem_wdata are driven from EX/MEM. The cycle counter increments every cycle.
  - BUSY → IDLE on the edge where mem_ack = 1. The load data (mem_rdata) is latched and done is set.
  - BUSY → IDLE when the counter reaches TIMEOUT with no ack. Load data is forced to 0, done is set, and mem_err is set. mem_err is cleared only by reset.
  - mem_ack is ignored in IDLE.
- freeze = mem_op & ~done (combinational). A memory op therefore stalls for the BUSY cycles plus one IDLE cycle.
- MEM/WB register, on each edge:
  - If freeze = 1: a bubble is inserted (WB_EN_wb = 0; Dest_wb and WB_Val hold).
  - Otherwise: WB_EN_wb = WB_EN_mem and Dest_wb = Dest_mem. WB_Val = latched load data if MEM_R_EN_mem, else ALU_Res.
- Non-memory ops pass through with one cycle per stage and no stall.
- Stores write nothing back, regardless of WB_EN.
- Back-to-back memory ops: done clears when the next op loads, so each op gets its own handshake.
- Address arithmetic is 32-bit unsigned, modulo 2^32. Values below ADDR_BASE wrap and are passed through unchecked.
- mem_ack and mem_rdata are sampled only on rising clk edges.

Test Plan:
- ALU op (result 0x0000_0005, Dest 3, WB_EN 1), no memory op → freeze stays 0; WB_Val = 5, Dest_wb = 3, WB_EN_wb = 1 exactly two edges after injection.
- Load, ALU_result 1032, memory acks 2 cycles after req with rdata 0xDEAD_BEEF → mem_addr = 2, mem_we = 0; freeze = 1 for 4 cycles; WB_Val = 0xDEAD_BEEF; one bubble (WB_EN_wb = 0) appears before the load result.
- Store, ALU_result 1028, val_Rm 0x1234, ack in the first req cycle → mem_we = 1, mem_addr = 1, mem_wdata = 0x1234; freeze high 2 cycles; WB_EN_wb = 0 for the store.
- Load with mem_ack never asserted → mem_req is held 15 cycles then drops; mem_err = 1; WB_Val = 0; pipeline resumes.
- Two consecutive loads → two separate req/ack handshakes with no request overlap; both results appear in order.
- rst asserted while in BUSY with mem_req = 1 → mem_req, freeze and all outputs are 0 immediately; a late ack after release causes no writeback.
